// File: rtl/ram_arbiter_if.sv
// Requester-side RAM access port: request/payload in, grant/done/read data out.
// The master modport is the requester; the slave modport is the arbiter.
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  gnt,
    input  done,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output gnt,
    output done,
    output rdata
  );

endinterface

// File: rtl/ram_arbiter.sv
// Shares one RAM port between the core (c) and an external master (e).
// Define ARB_BURST_LIMIT_EN to force ext in after MAX_BURST core grants.
module ram_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_BURST     = 4
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      c,
  ram_arbiter_if.slave      e,
  output logic              ram_ena,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wdata_oe,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  if (ACCESS_CYCLES < 1 || MAX_BURST < 1) begin : g_bad_cfg
    $error("ram_arbiter: ACCESS_CYCLES and MAX_BURST must be >= 1");
  end

  localparam int CW =
    (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          own_e;
  logic          we_q;
  logic          any_req;
  logic          pick_e;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign any_req = c.req | e.req;

`ifdef ARB_BURST_LIMIT_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  logic [BW-1:0] burst_cnt;
  logic          burst_full;

  assign burst_full = (burst_cnt == BMAX);
  assign pick_e     = e.req & (~c.req | burst_full);

  // Counts only core grants that made ext wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (pick_e || !e.req) begin
        burst_cnt <= '0;
      end else begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end
`else
  assign pick_e = e.req & ~c.req;
`endif

  assign sel_we    = pick_e ? e.we    : c.we;
  assign sel_addr  = pick_e ? e.addr  : c.addr;
  assign sel_wdata = pick_e ? e.wdata : c.wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      own_e        <= 1'b0;
      we_q         <= 1'b0;
      c.gnt        <= 1'b0;
      c.done       <= 1'b0;
      c.rdata      <= '0;
      e.gnt        <= 1'b0;
      e.done       <= 1'b0;
      e.rdata      <= '0;
      ram_ena      <= 1'b0;
      ram_read     <= 1'b0;
      ram_write    <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_wdata_oe <= 1'b0;
      busy         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state        <= ACC;
            cnt          <= '0;
            own_e        <= pick_e;
            we_q         <= sel_we;
            ram_addr     <= sel_addr;
            ram_wdata    <= sel_wdata;
            c.gnt        <= ~pick_e;
            e.gnt        <= pick_e;
            ram_ena      <= 1'b1;
            ram_read     <= ~sel_we;
            ram_write    <= sel_we;
            ram_wdata_oe <= sel_we;
            busy         <= 1'b1;
          end
        end
        ACC: begin
          if (cnt == LAST) begin
            state        <= RESP;
            ram_ena      <= 1'b0;
            ram_read     <= 1'b0;
            ram_write    <= 1'b0;
            ram_wdata_oe <= 1'b0;
            c.done       <= ~own_e;
            e.done       <= own_e;
            if (!we_q && !own_e) begin
              c.rdata <= ram_rdata;
            end
            if (!we_q && own_e) begin
              e.rdata <= ram_rdata;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state  <= IDLE;
          c.gnt  <= 1'b0;
          e.gnt  <= 1'b0;
          c.done <= 1'b0;
          e.done <= 1'b0;
          busy   <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
